// File: rtl/seq_det_pkg.sv
// Shared constants and the masked-compare helper for the parametrised sequence detector.
package seq_det_pkg;

    localparam int         PAT_W_DEF   = 4;
    localparam int         CNT_W_DEF   = 8;
    localparam logic [3:0] PAT_RST_DEF = 4'b0101;

    // Widest pattern the compare helper accepts; callers zero-extend narrower operands.
    localparam int         MAX_PAT_W   = 64;

    function automatic logic masked_eq(
        input logic [MAX_PAT_W-1:0] cand,
        input logic [MAX_PAT_W-1:0] pat,
        input logic [MAX_PAT_W-1:0] mask
    );
        return (((cand ^ pat) & mask) == {MAX_PAT_W{1'b0}});
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// Serial shift window with a saturating fill counter.
// full_minus_one flags that the next valid bit completes a window.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    output logic [PAT_W-1:0] window,
    output logic             full_minus_one
);

    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MO  = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  window_r;
    logic [FILL_W-1:0] fill_r;

    // Window shift and fill count; clear wins over shift so a load or a non-overlap match restarts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_r <= {PAT_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
        end else if (clear) begin
            window_r <= {PAT_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
        end else if (shift) begin
            window_r <= {window_r[PAT_W-2:0], din};
            if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            window_r <= window_r;
            fill_r   <= fill_r;
        end
    end

    assign window         = window_r;
    assign full_minus_one = (fill_r >= FILL_MO);

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with don't-care mask, overlap mode and saturating match counter.
// Optional macro SEQ_DET_MEALY_EN adds the zero-latency output flag_mealy.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_RST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             overlap_in,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt
`ifdef SEQ_DET_MEALY_EN
    ,
    output logic             flag_mealy
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_W-1:0]     pat_r;
    logic [PAT_W-1:0]     mask_r;
    logic                 overlap_r;
    logic                 flag_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [PAT_W-1:0]     window_s;
    logic                 full_minus_one_s;
    logic [PAT_W-1:0]     cand_s;
    logic [MAX_PAT_W-1:0] cand_w_s;
    logic [MAX_PAT_W-1:0] pat_w_s;
    logic [MAX_PAT_W-1:0] mask_w_s;
    logic                 match_s;
    logic                 shift_s;
    logic                 clear_s;

    assign shift_s = din_valid & ~pat_load;
    assign clear_s = pat_load | (match_s & ~overlap_r);

    seq_det_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear_s),
        .shift          (shift_s),
        .din            (din),
        .window         (window_s),
        .full_minus_one (full_minus_one_s)
    );

    // Candidate window including the bit on din, widened for the shared compare helper.
    always_comb begin
        cand_s   = PAT_W'({window_s, din});
        cand_w_s = {MAX_PAT_W{1'b0}};
        pat_w_s  = {MAX_PAT_W{1'b0}};
        mask_w_s = {MAX_PAT_W{1'b0}};
        cand_w_s[PAT_W-1:0] = cand_s;
        pat_w_s[PAT_W-1:0]  = pat_r;
        mask_w_s[PAT_W-1:0] = mask_r;
        if (shift_s && full_minus_one_s) begin
            match_s = masked_eq(cand_w_s, pat_w_s, mask_w_s);
        end else begin
            match_s = 1'b0;
        end
    end

    // Pattern, mask and overlap configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r     <= PAT_RST;
            mask_r    <= {PAT_W{1'b1}};
            overlap_r <= 1'b1;
        end else if (pat_load) begin
            pat_r     <= pat_in;
            mask_r    <= mask_in;
            overlap_r <= overlap_in;
        end else begin
            pat_r     <= pat_r;
            mask_r    <= mask_r;
            overlap_r <= overlap_r;
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_r <= 1'b0;
        end else begin
            flag_r <= match_s;
        end
    end

    // Saturating match counter; a clear drops a coincident match from the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (match_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign flag      = flag_r;
    assign match_cnt = cnt_r;

`ifdef SEQ_DET_MEALY_EN
    assign flag_mealy = match_s;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (default build and SEQ_DET_MEALY_EN build).
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       pat_load;
    logic [3:0] pat_in;
    logic [3:0] mask_in;
    logic       overlap_in;
    logic       cnt_clr;
    logic       flag;
    logic       flag_s2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt_s2;
`ifdef SEQ_DET_MEALY_EN
    logic       flag_mealy;
    logic       flag_mealy_s2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [15:0] STREAM = 16'b0100_0110_0101_0101;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .mask_in    (mask_in),
        .overlap_in (overlap_in),
        .cnt_clr    (cnt_clr),
        .flag       (flag),
        .match_cnt  (match_cnt)
`ifdef SEQ_DET_MEALY_EN
        ,
        .flag_mealy (flag_mealy)
`endif
    );

    seq_detector_param #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .mask_in    (mask_in),
        .overlap_in (overlap_in),
        .cnt_clr    (cnt_clr),
        .flag       (flag_s2),
        .match_cnt  (match_cnt_s2)
`ifdef SEQ_DET_MEALY_EN
        ,
        .flag_mealy (flag_mealy_s2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; exp is the match expected for this cycle.
    task automatic cyc(input logic v, input logic b, input logic ld, input logic clr,
                       input logic r, input logic exp, input string tag);
        @(negedge clk);
        din       = b;
        din_valid = v;
        pat_load  = ld;
        cnt_clr   = clr;
        rst       = r;
`ifdef SEQ_DET_MEALY_EN
        #1;
        chk({tag, "_mealy"}, 32'(flag_mealy), 32'(exp));
        chk({tag, "_mealy2"}, 32'(flag_mealy_s2), 32'(exp));
`endif
        @(posedge clk);
        #1;
        chk({tag, "_flag"}, 32'(flag), 32'(exp));
        chk({tag, "_flag2"}, 32'(flag_s2), 32'(exp));
    endtask

    task automatic send(input logic b, input logic exp, input string tag);
        cyc(1'b1, b, 1'b0, 1'b0, 1'b0, exp, tag);
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m, input logic o,
                        input logic v, input logic b);
        pat_in     = p;
        mask_in    = m;
        overlap_in = o;
        cyc(v, b, 1'b1, 1'b1, 1'b0, 1'b0, "load");
    endtask

    // Stream 16 bits MSB first; e[i] is the flag expected after bit i; gap>0 inserts bubbles.
    task automatic run_stream(input logic [15:0] s, input logic [15:0] e, input int gap,
                              input string tag);
        for (int i = 0; i < 16; i++) begin
            if (gap != 0 && (i % gap) == 1) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bubble");
            end
            cyc(1'b1, s[15-i], 1'b0, 1'b0, 1'b0, e[i], tag);
        end
    endtask

    initial begin
        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        pat_load   = 1'b0;
        pat_in     = 4'b0000;
        mask_in    = 4'b0000;
        overlap_in = 1'b0;
        cnt_clr    = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
        chk("reset_cnt", 32'(match_cnt), 32'd0);

        run_stream(STREAM, 16'hA800, 0, "ovl");
        chk("ovl_cnt", 32'(match_cnt), 32'd3);

        load(4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("load_cnt_clr", 32'(match_cnt), 32'd0);
        run_stream(STREAM, 16'h8800, 0, "novl");
        chk("novl_cnt", 32'(match_cnt), 32'd2);

        load(4'b0101, 4'b1011, 1'b1, 1'b0, 1'b0);
        run_stream(STREAM, 16'hA820, 0, "mask");
        chk("mask_cnt", 32'(match_cnt), 32'd4);

        load(4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0);
        run_stream(STREAM, 16'hA800, 3, "gap");
        chk("gap_cnt", 32'(match_cnt), 32'd3);

        // Load with a valid 0 on din: that bit must not enter the window.
        load(4'b0101, 4'b1111, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, "prio");
        send(1'b0, 1'b0, "prio");
        send(1'b1, 1'b0, "prio");
        send(1'b0, 1'b0, "prio");
        send(1'b1, 1'b1, "prio");
        chk("prio_cnt", 32'(match_cnt), 32'd1);

        load(4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            send(i[0], (i >= 3) && i[0], "sat");
        end
        chk("sat_cnt2", 32'(match_cnt_s2), 32'd3);
        chk("sat_cnt8", 32'(match_cnt), 32'd15);
        send(1'b0, 1'b0, "clr");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "clr_match");
        chk("clr_cnt2", 32'(match_cnt_s2), 32'd0);
        chk("clr_cnt8", 32'(match_cnt), 32'd0);
        send(1'b0, 1'b0, "after_clr");
        send(1'b1, 1'b1, "after_clr");
        chk("after_clr_cnt", 32'(match_cnt), 32'd1);

        // Mid-stream reset: partial window dropped and reset pattern/overlap restored.
        load(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, "pre_rst");
        send(1'b1, 1'b0, "pre_rst");
        send(1'b0, 1'b0, "pre_rst");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mid_rst");
        send(1'b1, 1'b0, "post_rst");
        chk("post_rst_cnt", 32'(match_cnt), 32'd0);
        send(1'b0, 1'b0, "rst_pat");
        send(1'b1, 1'b0, "rst_pat");
        send(1'b0, 1'b0, "rst_pat");
        send(1'b1, 1'b1, "rst_pat");
        send(1'b0, 1'b0, "rst_pat");
        send(1'b1, 1'b1, "rst_pat");
        chk("rst_pat_cnt", 32'(match_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed Mealy/Moore sequence detectors.
- Consumes one serial bit per valid cycle, first bit MSB, and compares a PAT_W-bit sliding window against a runtime-loadable pattern with a don't-care mask.
- Outputs: registered one-cycle match pulse `flag`, overlap/non-overlap mode, and a saturating match counter.
- Sits between a serial source (UART/line decoder) and control logic.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 8, width of match counter.
- PAT_RST, 4'b0101 (PAT_W bits), pattern active after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din consumed on a rising edge where din_valid=1.
- pat_load  input  1  capture pat_in/mask_in/overlap_in this cycle.
- pat_in  input  PAT_W  new pattern; bit PAT_W-1 = first bit of sequence.
- mask_in  input  PAT_W  per-bit compare enable; 0 = don't care.
- overlap_in  input  1  1 = overlapping matches allowed.
- cnt_clr  input  1  clear match counter.
- flag  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset, sync on clk when rst=1:
  - window=0, fill=0, flag=0, match_cnt=0.
  - pat_r=PAT_RST, mask_r=all ones, overlap_r=1.
  - rst overrides all other inputs. Reset mid-stream discards partial window.
- Window:
  - On valid bit: window <= {window[PAT_W-2:0], din}.
  - fill counter 0..PAT_W increments and saturates at PAT_W.
- Match, combinational: din_valid && fill>=PAT_W-1 && ((({window[PAT_W-2:0],din} ^ pat_r) & mask_r) == 0).
- Latency:
  - flag <= match. flag is high exactly the cycle after the last pattern bit is sampled, for one cycle.
  - Otherwise flag=0.
- Overlap:
  - overlap_r=1: window/fill continue, so a suffix can start the next match.
  - overlap_r=0: on match, fill <= 0 and window is cleared, so the next match needs PAT_W fresh bits.
- pat_load=1:
  - pat_r/mask_r/overlap_r <= inputs; window=0, fill=0, flag <= 0.
  - din is ignored that cycle, even if din_valid=1.
  - pat_load has priority over din_valid.
- mask_r all zero: any full window matches.
- din_valid=0: no state change except flag deasserts (flag <= 0) and the counter clear (below).
- Counter:
  - On match, match_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - cnt_clr=1: match_cnt <= 0. This takes priority over a simultaneous match; that match is not counted but flag still pulses.

Optional Feature:
- Macro SEQ_DET_MEALY_EN.
- Defined:
  - Adds output port flag_mealy (1 bit) = combinational match term.
  - Asserts in the same cycle the last bit is presented (Mealy timing), zero latency.
- Undefined: port absent; only the registered flag exists. All other behaviour is identical.

Decomposition:
- Package seq_det_pkg holds:
  - default PAT_W/CNT_W/PAT_RST constants;
  - a function for masked compare.
- Sub-module seq_det_window contains the shift register plus fill counter, with clear and saturation; it outputs window and full_minus_one.
- The top-level block contains the pattern registers, match logic, flag register and counter.

Test Plan:
- Default pattern 0101, overlap=1, stream 0100_0110_0101_0101 MSB first, one bit/cycle:
  - flag pulses after bits 11, 13, 15 (0-indexed);
  - match_cnt=3.
- Same stream after pat_load with overlap_in=0: flag after bits 11 and 15 only; match_cnt=2.
- pat_in=0101, mask_in=1011, overlap=1, same stream: flag after bits 5, 11, 13, 15; match_cnt=4.
- CNT_W=2, stream 0101 repeated 8 times, overlap=1: match_cnt saturates at 3; cnt_clr asserted on a match cycle -> flag still pulses, match_cnt=0.
- din_valid toggled 0/1 with bubbles inserted mid-pattern: matches identical to the gapless run; flag never asserts on an invalid cycle.
- rst asserted after 3 of 4 pattern bits, then bits 1 alone: no flag. With SEQ_DET_MEALY_EN defined: flag_mealy high on the same cycle as the last bit, and flag one cycle later.
